// File: rtl/sr_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sr_axi_bridge_pkg
//
// Shared types and helpers for the sr_axi_bridge_mo memory-port-to-AXI bridge.
//   - AXI response and burst encodings
//   - axi_mosi_t / axi_miso_t single-beat AXI4 master carrier structs
//   - axsize(): AxSIZE encoding for a given data width
//
// The carrier structs have fixed field widths (AXI_*_W below). The bridge
// zero-extends or truncates its own parameterised fields into them.
// -----------------------------------------------------------------------------
package sr_axi_bridge_pkg;

    localparam int AXI_ADDR_W = 16;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_IDW_W  = 4;
    localparam int AXI_IDR_W  = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef struct packed {
        logic [AXI_IDW_W-1:0]  awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [AXI_IDR_W-1:0]  arid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_IDW_W-1:0]  bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_IDR_W-1:0]  rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } axi_miso_t;

    // AxSIZE = log2(bytes per beat).
    function automatic logic [2:0] axsize(input int data_width);
        int         bytes;
        logic [2:0] size;
        bytes = data_width / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/sr_axi_bridge_order_fifo.sv
// -----------------------------------------------------------------------------
// sr_axi_bridge_order_fifo
//
// Small 1-bit-wide FIFO recording the op type (1 = write, 0 = read) of every
// accepted request, so responses can be steered back in request order.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          push push_data_i (ignored when full)
//   push_data_i     1 = write, 0 = read
//   pop_i           pop head (ignored when empty)
//   head_o          current head entry
//   full_o/empty_o  status
//   count_o         number of stored entries
// -----------------------------------------------------------------------------
module sr_axi_bridge_order_fifo
    import sr_axi_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   push_data_i,
    input  logic                   pop_i,
    output logic                   head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full_o   = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;

        // Depth is a power of two, so the pointers wrap on overflow.
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign mem_d[gi] = (push_ok && (wr_ptr_q == PTR_W'(gi))) ? push_data_i : mem_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sr_axi_bridge_mo.sv
// -----------------------------------------------------------------------------
// sr_axi_bridge_mo
//
// Multi-outstanding bridge from the sr_cpu mem port (req/resp valid-ready) to a
// single-beat AXI4 master port. Up to MAX_OUTSTANDING mixed reads and writes
// may be in flight; responses return to the core strictly in request order.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_wr_i            1 = write, 0 = read
//   mem_addr_i          byte address
//   mem_be_i            write byte enables
//   mem_wdata_i         write data
//   mem_req_valid_i     request valid
//   mem_req_ready_o     request accepted
//   mem_resp_valid_o    response valid (reads and writes)
//   mem_resp_ready_i    core accepts response
//   mem_rdata_o         read data, 0 for write responses
//   out_mosi_o          AXI master outputs
//   out_miso_i          AXI master inputs
//
// Optional (macro SR_AXI_BRIDGE_RESP_ERR_EN):
//   mem_resp_err_o      1 when the BRESP/RRESP of this response was not OKAY
//   err_cnt_o           saturating count of error responses
// -----------------------------------------------------------------------------
module sr_axi_bridge_mo
    import sr_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_W_WIDTH      = 4,
    parameter int ID_R_WIDTH      = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_wr_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic                    mem_req_valid_i,
    output logic                    mem_req_ready_o,
    output logic                    mem_resp_valid_o,
    input  logic                    mem_resp_ready_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
    output logic                    mem_resp_err_o,
    output logic [7:0]              err_cnt_o,
`endif
    output axi_mosi_t               out_mosi_o,
    input  axi_miso_t               out_miso_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [2:0]            AXSIZE_C = axsize(DATA_WIDTH);
    localparam logic [ID_W_WIDTH-1:0] AWID_C   = ID_W_WIDTH'(AXI_ID);
    localparam logic [ID_R_WIDTH-1:0] ARID_C   = ID_R_WIDTH'(AXI_ID);

    // Issue-stage holding register.
    logic                  live_q,    live_d;     // low in the cycle(s) after reset
    logic                  busy_q,    busy_d;
    logic                  wr_q,      wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [BE_W-1:0]       be_q,      be_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;

    // Response output register.
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;

    logic aw_valid, w_valid, ar_valid;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic b_ready, r_ready;
    logic req_ready, req_fire;
    logic out_free, pop;

    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Fields of the AXI inputs the bridge has no use for.
    logic unused_miso;

    sr_axi_bridge_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_fire),
        .push_data_i (mem_wr_i),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // ---------------------------------------------------------------- issue
    always_comb begin
        aw_valid = busy_q && wr_q && !aw_done_q;
        w_valid  = busy_q && wr_q && !w_done_q;
        ar_valid = busy_q && !wr_q;
        aw_hs    = aw_valid && out_miso_i.awready;
        w_hs     = w_valid  && out_miso_i.wready;
        ar_hs    = ar_valid && out_miso_i.arready;

        // The FIFO count includes the request sitting in the holding register;
        // a pop in the same cycle does not bypass a full FIFO.
        req_ready = live_q && !busy_q && !fifo_full && (fifo_count < CNT_W'(MAX_OUTSTANDING));
        req_fire  = mem_req_valid_i && req_ready;

        live_d    = 1'b1;
        busy_d    = busy_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        if (req_fire) begin
            busy_d    = 1'b1;
            wr_d      = mem_wr_i;
            addr_d    = mem_addr_i;
            be_d      = mem_wr_i ? mem_be_i    : '0;
            wdata_d   = mem_wr_i ? mem_wdata_i : '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (busy_q) begin
            if (wr_q) begin
                // AW and W complete independently; the slot frees once both have.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q  || w_hs;
                if (aw_done_d && w_done_d) begin
                    busy_d = 1'b0;
                end
            end else if (ar_hs) begin
                busy_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- response
    always_comb begin
        out_free = !resp_valid_q || mem_resp_ready_i;
        // Only the channel matching the oldest outstanding op is accepted; the
        // other channel is held off until that response has been consumed.
        b_ready  = !fifo_empty && fifo_head  && out_free;
        r_ready  = !fifo_empty && !fifo_head && out_free;
        b_hs     = b_ready && out_miso_i.bvalid;
        r_hs     = r_ready && out_miso_i.rvalid;
        pop      = b_hs || r_hs;

        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        if (pop) begin
            resp_valid_d = 1'b1;
            rdata_d      = r_hs ? DATA_WIDTH'(out_miso_i.rdata) : '0;
        end else if (mem_resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
    logic       resp_err_q, resp_err_d;
    logic [7:0] err_cnt_q,  err_cnt_d;

    always_comb begin
        resp_err_d = resp_err_q;
        err_cnt_d  = err_cnt_q;
        if (pop) begin
            resp_err_d = r_hs ? (out_miso_i.rresp != RESP_OKAY)
                              : (out_miso_i.bresp != RESP_OKAY);
            if (resp_err_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            resp_err_q <= resp_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mem_resp_err_o = resp_err_q;
    assign err_cnt_o      = err_cnt_q;
    assign unused_miso    = ^{out_miso_i.bid, out_miso_i.rid, out_miso_i.rlast};
`else
    assign unused_miso    = ^{out_miso_i.bid, out_miso_i.rid, out_miso_i.rlast,
                              out_miso_i.bresp, out_miso_i.rresp};
`endif

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q       <= 1'b0;
            busy_q       <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            live_q       <= live_d;
            busy_q       <= busy_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------ AXI drive
    // Payload fields are zero whenever their VALID is low, so the port is all
    // zeros in reset and idle.
    always_comb begin
        out_mosi_o = '0;

        out_mosi_o.awvalid = aw_valid;
        if (aw_valid) begin
            out_mosi_o.awid    = AXI_IDW_W'(AWID_C);
            out_mosi_o.awaddr  = AXI_ADDR_W'(addr_q);
            out_mosi_o.awlen   = 8'd0;
            out_mosi_o.awsize  = AXSIZE_C;
            out_mosi_o.awburst = BURST_INCR;
        end

        out_mosi_o.wvalid = w_valid;
        if (w_valid) begin
            out_mosi_o.wdata = AXI_DATA_W'(wdata_q);
            out_mosi_o.wstrb = AXI_STRB_W'(be_q);
            out_mosi_o.wlast = 1'b1;
        end

        out_mosi_o.arvalid = ar_valid;
        if (ar_valid) begin
            out_mosi_o.arid    = AXI_IDR_W'(ARID_C);
            out_mosi_o.araddr  = AXI_ADDR_W'(addr_q);
            out_mosi_o.arlen   = 8'd0;
            out_mosi_o.arsize  = AXSIZE_C;
            out_mosi_o.arburst = BURST_INCR;
        end

        out_mosi_o.bready = b_ready;
        out_mosi_o.rready = r_ready;
    end

    assign mem_req_ready_o  = req_ready;
    assign mem_resp_valid_o = resp_valid_q;
    assign mem_rdata_o      = rdata_q;

endmodule

// File: tb/tb_sr_axi_bridge_mo.sv
`timescale 1ns/1ps
module tb_sr_axi_bridge_mo;
    import sr_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_wr_i = 1'b0;
    logic [15:0] mem_addr_i = '0;
    logic [3:0]  mem_be_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_req_valid_i = 1'b0;
    logic        mem_req_ready_o;
    logic        mem_resp_valid_o;
    logic        mem_resp_ready_i = 1'b1;
    logic [31:0] mem_rdata_o;
`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
    logic        mem_resp_err_o;
    logic [7:0]  err_cnt_o;
`endif
    axi_mosi_t   mosi;
    axi_miso_t   miso = '0;

    int total = 0;
    int bad   = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, req_cnt = 0;
    logic [31:0] resp_q[$];

    always #5 clk = ~clk;

    sr_axi_bridge_mo #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (32),
        .ID_W_WIDTH      (4),
        .ID_R_WIDTH      (4),
        .AXI_ID          (0),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_wr_i         (mem_wr_i),
        .mem_addr_i       (mem_addr_i),
        .mem_be_i         (mem_be_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_req_valid_i  (mem_req_valid_i),
        .mem_req_ready_o  (mem_req_ready_o),
        .mem_resp_valid_o (mem_resp_valid_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .mem_rdata_o      (mem_rdata_o),
`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
        .mem_resp_err_o   (mem_resp_err_o),
        .err_cnt_o        (err_cnt_o),
`endif
        .out_mosi_o       (mosi),
        .out_miso_i       (miso)
    );

    // Handshake monitor: one line per completed transaction.
    always @(posedge clk) begin
        if (!rst) begin
            if (mosi.awvalid && miso.awready) aw_cnt <= aw_cnt + 1;
            if (mosi.wvalid && miso.wready)   w_cnt  <= w_cnt + 1;
            if (mosi.arvalid && miso.arready) ar_cnt <= ar_cnt + 1;
            if (mem_req_valid_i && mem_req_ready_o) begin
                req_cnt <= req_cnt + 1;
                $display("%0t req  wr=%0b addr=%h", $time, mem_wr_i, mem_addr_i);
            end
            if (mem_resp_valid_o && mem_resp_ready_i) begin
                resp_q.push_back(mem_rdata_o);
                $display("%0t resp rdata=%h", $time, mem_rdata_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        #1;
        total++; if (mem_req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", mem_req_ready_o); end
        total++; if (mem_resp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", mem_resp_valid_o); end
        total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", mem_rdata_o); end
        total++; if (mosi !== '0) begin bad++; $display("FAIL reset_mosi: got %h want 0", mosi); end
        rst = 1'b0;
        step();
        total++; if (mem_req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", mem_req_ready_o); end
    endtask

    task automatic test_read();
        int base_ar, base_r;
        step();
        base_ar = ar_cnt; base_r = resp_q.size();
        mem_wr_i = 1'b0; mem_addr_i = 16'h0040; mem_req_valid_i = 1'b1;
        #1;
        total++; if (mem_req_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", mem_req_ready_o); end
        step();
        mem_req_valid_i = 1'b0;
        #1;
        total++; if (mosi.arvalid !== 1'b1) begin bad++; $display("FAIL rd_arvalid: got %b want 1", mosi.arvalid); end
        total++; if (mosi.araddr !== 16'h0040) begin bad++; $display("FAIL rd_araddr: got %h want 0040", mosi.araddr); end
        total++; if (mosi.arlen !== 8'd0 || mosi.arsize !== 3'd2 || mosi.arid !== 4'd0 || mosi.arburst !== 2'b01) begin
            bad++; $display("FAIL rd_ar_fields: got len=%0d size=%0d id=%0d burst=%0d want 0/2/0/1", mosi.arlen, mosi.arsize, mosi.arid, mosi.arburst);
        end
        total++; if (mem_req_ready_o !== 1'b0) begin bad++; $display("FAIL rd_ready_busy: got %b want 0", mem_req_ready_o); end
        miso.arready = 1'b1;
        step();
        miso.arready = 1'b0;
        #1;
        total++; if (mosi.arvalid !== 1'b0) begin bad++; $display("FAIL rd_arvalid_drop: got %b want 0", mosi.arvalid); end
        step();
        miso.rvalid = 1'b1; miso.rdata = 32'hDEADBEEF; miso.rresp = 2'b00;
        #1;
        total++; if (mosi.rready !== 1'b1) begin bad++; $display("FAIL rd_rready: got %b want 1", mosi.rready); end
        step();
        miso.rvalid = 1'b0;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_resp: got v=%b d=%h want v=1 d=deadbeef", mem_resp_valid_o, mem_rdata_o);
        end
        step();
        total++; if (mem_resp_valid_o !== 1'b0) begin bad++; $display("FAIL rd_resp_clear: got %b want 0", mem_resp_valid_o); end
        total++; if (resp_q.size() != base_r + 1 || ar_cnt - base_ar != 1) begin
            bad++; $display("FAIL rd_counts: got resp=%0d ar=%0d want 1/1", resp_q.size() - base_r, ar_cnt - base_ar);
        end
    endtask

    task automatic test_write();
        int base_aw, base_w, base_r;
        step();
        base_aw = aw_cnt; base_w = w_cnt; base_r = resp_q.size();
        mem_wr_i = 1'b1; mem_addr_i = 16'h0010; mem_wdata_i = 32'h12345678; mem_be_i = 4'b0011;
        mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0; miso.wready = 1'b1;
        #1;
        total++; if (mosi.awvalid !== 1'b1 || mosi.wvalid !== 1'b1) begin
            bad++; $display("FAIL wr_valids: got aw=%b w=%b want 1/1", mosi.awvalid, mosi.wvalid);
        end
        total++; if (mosi.wstrb !== 4'b0011 || mosi.wlast !== 1'b1 || mosi.wdata !== 32'h12345678) begin
            bad++; $display("FAIL wr_wfields: got strb=%b last=%b data=%h want 0011/1/12345678", mosi.wstrb, mosi.wlast, mosi.wdata);
        end
        total++; if (mosi.awaddr !== 16'h0010 || mosi.awsize !== 3'd2 || mosi.awlen !== 8'd0) begin
            bad++; $display("FAIL wr_awfields: got addr=%h size=%0d len=%0d want 0010/2/0", mosi.awaddr, mosi.awsize, mosi.awlen);
        end
        step();
        miso.wready = 1'b0;
        #1;
        total++; if (mosi.wvalid !== 1'b0 || mosi.awvalid !== 1'b1) begin
            bad++; $display("FAIL wr_w_drop: got w=%b aw=%b want 0/1", mosi.wvalid, mosi.awvalid);
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_req_ready_o !== 1'b0 || mosi.wvalid !== 1'b0) begin
                bad++; $display("FAIL wr_ready_hold%0d: got ready=%b wvalid=%b want 0/0", i, mem_req_ready_o, mosi.wvalid);
            end
            step();
            #1;
        end
        miso.awready = 1'b1;
        step();
        miso.awready = 1'b0;
        #1;
        total++; if (mosi.awvalid !== 1'b0 || mem_req_ready_o !== 1'b1) begin
            bad++; $display("FAIL wr_aw_done: got awvalid=%b ready=%b want 0/1", mosi.awvalid, mem_req_ready_o);
        end
        total++; if (aw_cnt - base_aw != 1 || w_cnt - base_w != 1) begin
            bad++; $display("FAIL wr_hs_counts: got aw=%0d w=%0d want 1/1", aw_cnt - base_aw, w_cnt - base_w);
        end
        miso.bvalid = 1'b1; miso.bresp = 2'b00;
        #1;
        total++; if (mosi.bready !== 1'b1) begin bad++; $display("FAIL wr_bready: got %b want 1", mosi.bready); end
        step();
        miso.bvalid = 1'b0;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'h0) begin
            bad++; $display("FAIL wr_resp: got v=%b d=%h want v=1 d=0", mem_resp_valid_o, mem_rdata_o);
        end
        step();
        total++; if (resp_q.size() != base_r + 1) begin bad++; $display("FAIL wr_resp_count: got %0d want 1", resp_q.size() - base_r); end
    endtask

    task automatic test_max_outstanding();
        int base_req, base_ar, base_r;
        step();
        base_req = req_cnt; base_ar = ar_cnt; base_r = resp_q.size();
        miso.arready = 1'b1;
        mem_wr_i = 1'b0; mem_addr_i = 16'h0100; mem_req_valid_i = 1'b1;
        repeat (12) step();
        #1;
        total++; if (req_cnt - base_req != 4 || ar_cnt - base_ar != 4) begin
            bad++; $display("FAIL mo_issued: got req=%0d ar=%0d want 4/4", req_cnt - base_req, ar_cnt - base_ar);
        end
        total++; if (mem_req_ready_o !== 1'b0) begin bad++; $display("FAIL mo_ready_full: got %b want 0", mem_req_ready_o); end
        miso.rvalid = 1'b1; miso.rdata = 32'h11110001;
        step();
        miso.rvalid = 1'b0;
        #1;
        total++; if (mem_req_ready_o !== 1'b1 || mem_resp_valid_o !== 1'b1) begin
            bad++; $display("FAIL mo_after_pop: got ready=%b resp_valid=%b want 1/1", mem_req_ready_o, mem_resp_valid_o);
        end
        step();
        mem_req_valid_i = 1'b0;
        #1;
        total++; if (req_cnt - base_req != 5) begin bad++; $display("FAIL mo_fifth: got %0d want 5", req_cnt - base_req); end
        step();
        for (int i = 0; i < 4; i++) begin
            miso.rvalid = 1'b1; miso.rdata = 32'h22220000 + 32'(i);
            step();
        end
        miso.rvalid = 1'b0; miso.arready = 1'b0;
        step();
        #1;
        total++; if (ar_cnt - base_ar != 5 || resp_q.size() - base_r != 5) begin
            bad++; $display("FAIL mo_drain: got ar=%0d resp=%0d want 5/5", ar_cnt - base_ar, resp_q.size() - base_r);
        end else begin
            total++; if (resp_q[base_r] !== 32'h11110001 || resp_q[base_r + 4] !== 32'h22220003) begin
                bad++; $display("FAIL mo_order: got %h..%h want 11110001..22220003", resp_q[base_r], resp_q[base_r + 4]);
            end
        end
    endtask

    task automatic test_order();
        int base_r;
        step();
        base_r = resp_q.size();
        miso.awready = 1'b1; miso.wready = 1'b1; miso.arready = 1'b1;
        mem_wr_i = 1'b1; mem_addr_i = 16'h0020; mem_wdata_i = 32'h55AA55AA; mem_be_i = 4'hF;
        mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0;
        step();
        mem_wr_i = 1'b0; mem_addr_i = 16'h0024; mem_req_valid_i = 1'b1;
        #1;
        total++; if (mem_req_ready_o !== 1'b1) begin bad++; $display("FAIL ord_ready2: got %b want 1", mem_req_ready_o); end
        step();
        mem_req_valid_i = 1'b0;
        step();
        miso.awready = 1'b0; miso.wready = 1'b0; miso.arready = 1'b0;
        miso.rvalid = 1'b1; miso.rdata = 32'hCAFEF00D;
        #1;
        total++; if (mosi.rready !== 1'b0) begin bad++; $display("FAIL ord_rready_blocked: got %b want 0", mosi.rready); end
        step();
        total++; if (mosi.rready !== 1'b0 || mem_resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL ord_stall: got rready=%b resp_valid=%b want 0/0", mosi.rready, mem_resp_valid_o);
        end
        miso.bvalid = 1'b1;
        #1;
        total++; if (mosi.bready !== 1'b1 || mosi.rready !== 1'b0) begin
            bad++; $display("FAIL ord_bready: got bready=%b rready=%b want 1/0", mosi.bready, mosi.rready);
        end
        step();
        miso.bvalid = 1'b0;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'h0 || mosi.rready !== 1'b1) begin
            bad++; $display("FAIL ord_wresp: got v=%b d=%h rready=%b want 1/0/1", mem_resp_valid_o, mem_rdata_o, mosi.rready);
        end
        step();
        miso.rvalid = 1'b0;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'hCAFEF00D) begin
            bad++; $display("FAIL ord_rresp: got v=%b d=%h want 1/cafef00d", mem_resp_valid_o, mem_rdata_o);
        end
        step();
        total++; if (resp_q.size() - base_r != 2) begin
            bad++; $display("FAIL ord_count: got %0d want 2", resp_q.size() - base_r);
        end else begin
            total++; if (resp_q[base_r] !== 32'h0 || resp_q[base_r + 1] !== 32'hCAFEF00D) begin
                bad++; $display("FAIL ord_seq: got %h,%h want 0,cafef00d", resp_q[base_r], resp_q[base_r + 1]);
            end
        end
    endtask

    task automatic test_resp_stall();
        int base_r;
        step();
        base_r = resp_q.size();
        miso.arready = 1'b1;
        mem_wr_i = 1'b0; mem_addr_i = 16'h0030; mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0;
        step();
        mem_addr_i = 16'h0034; mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0;
        step();
        miso.arready = 1'b0;
        mem_resp_ready_i = 1'b0;
        miso.rvalid = 1'b1; miso.rdata = 32'hA1A1A1A1;
        #1;
        total++; if (mosi.rready !== 1'b1) begin bad++; $display("FAIL stall_rready1: got %b want 1", mosi.rready); end
        step();
        miso.rdata = 32'hB2B2B2B2;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'hA1A1A1A1 || mosi.rready !== 1'b0) begin
            bad++; $display("FAIL stall_first: got v=%b d=%h rready=%b want 1/a1a1a1a1/0", mem_resp_valid_o, mem_rdata_o, mosi.rready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'hA1A1A1A1 || mosi.rready !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d: got v=%b d=%h rready=%b want 1/a1a1a1a1/0", i, mem_resp_valid_o, mem_rdata_o, mosi.rready);
            end
        end
        mem_resp_ready_i = 1'b1;
        #1;
        total++; if (mosi.rready !== 1'b1) begin bad++; $display("FAIL stall_rready2: got %b want 1", mosi.rready); end
        step();
        miso.rvalid = 1'b0;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_rdata_o !== 32'hB2B2B2B2) begin
            bad++; $display("FAIL stall_second: got v=%b d=%h want 1/b2b2b2b2", mem_resp_valid_o, mem_rdata_o);
        end
        step();
        total++; if (resp_q.size() - base_r != 2) begin
            bad++; $display("FAIL stall_count: got %0d want 2", resp_q.size() - base_r);
        end else begin
            total++; if (resp_q[base_r] !== 32'hA1A1A1A1 || resp_q[base_r + 1] !== 32'hB2B2B2B2) begin
                bad++; $display("FAIL stall_seq: got %h,%h want a1a1a1a1,b2b2b2b2", resp_q[base_r], resp_q[base_r + 1]);
            end
        end
    endtask

`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
    task automatic test_resp_err();
        step();
        miso.arready = 1'b1;
        mem_wr_i = 1'b0; mem_addr_i = 16'h0050; mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0;
        step();
        miso.arready = 1'b0;
        miso.rvalid = 1'b1; miso.rdata = 32'h0BAD0BAD; miso.rresp = 2'b10;
        step();
        miso.rvalid = 1'b0; miso.rresp = 2'b00;
        #1;
        total++; if (mem_resp_valid_o !== 1'b1 || mem_resp_err_o !== 1'b1) begin
            bad++; $display("FAIL err_flag: got v=%b err=%b want 1/1", mem_resp_valid_o, mem_resp_err_o);
        end
        total++; if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL err_cnt: got %0d want 1", err_cnt_o); end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        step();
        miso.arready = 1'b0;
        mem_wr_i = 1'b0; mem_addr_i = 16'h0060; mem_req_valid_i = 1'b1;
        step();
        mem_req_valid_i = 1'b0;
        #1;
        total++; if (mosi.arvalid !== 1'b1) begin bad++; $display("FAIL mid_arvalid: got %b want 1", mosi.arvalid); end
        rst = 1'b1;
        step();
        total++; if (mosi !== '0 || mem_req_ready_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset_axi: got mosi=%h ready=%b want 0/0", mosi, mem_req_ready_o);
        end
        total++; if (mem_resp_valid_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
            bad++; $display("FAIL mid_reset_resp: got v=%b d=%h want 0/0", mem_resp_valid_o, mem_rdata_o);
        end
`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
        total++; if (mem_resp_err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            bad++; $display("FAIL mid_reset_err: got err=%b cnt=%0d want 0/0", mem_resp_err_o, err_cnt_o);
        end
`endif
        rst = 1'b0;
        step();
        total++; if (mem_req_ready_o !== 1'b1 || mosi.arvalid !== 1'b0) begin
            bad++; $display("FAIL mid_after: got ready=%b arvalid=%b want 1/0", mem_req_ready_o, mosi.arvalid);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_max_outstanding();
        test_order();
        test_resp_stall();
`ifdef SR_AXI_BRIDGE_RESP_ERR_EN
        test_resp_err();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
